bcd: RTL and testbench

BCD -- requirements
Module: bcd

---
 rtl/bcd_if.sv | 38 +++
 rtl/bcd.sv | 103 ++++++++++
 tb/tb_bcd.sv | 376 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_if.sv
// BCD decoder bus: the asynchronous code inputs, enable/clear controls and
// the registered one-hot decimal outputs with error flag and error counter.
interface bcd_if #(
  parameter int CNT_W = 8
);

  logic             en;
  logic             clr_cnt;
  logic             A0;
  logic             A1;
  logic             A2;
  logic             A3;
  logic             O0;
  logic             O1;
  logic             O2;
  logic             O3;
  logic             O4;
  logic             O5;
  logic             O6;
  logic             O7;
  logic             O8;
  logic             O9;
  logic             ERR;
  logic [CNT_W-1:0] ERR_CNT;

  // Side that supplies the code and controls and observes the decode
  modport master (
    output en, clr_cnt, A0, A1, A2, A3,
    input  O0, O1, O2, O3, O4, O5, O6, O7, O8, O9, ERR, ERR_CNT
  );

  // Decoder side
  modport slave (
    input  en, clr_cnt, A0, A1, A2, A3,
    output O0, O1, O2, O3, O4, O5, O6, O7, O8, O9, ERR, ERR_CNT
  );

endinterface

// File: rtl/bcd.sv
// BCD-to-decimal decoder with input synchronizers, registered one-hot
// outputs, an invalid-code flag and a saturating count of invalid-code entries.
//
// SYNC_STAGES must lie in 1..4. The A inputs may change at any time relative
// to clk, so they only reach the decode logic through the synchronizer chain.
// Every output comes straight from a flop, so nothing downstream ever sees
// a combinational glitch.
module bcd #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic rst_n,
  bcd_if.slave bus
);

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  // Synchronizer chain, stage 0 is closest to the pins
  logic [3:0]       syncChain_q [SYNC_STAGES];
  logic [3:0]       syncCode;

  // Registered decode state
  logic [9:0]       oneHot_q;
  logic [9:0]       oneHot_d;
  logic             err_q;
  logic             err_d;
  logic [CNT_W-1:0] errCnt_q;
  logic [CNT_W-1:0] errCnt_d;
  logic             errRise;

  assign syncCode = syncChain_q[SYNC_STAGES-1];

  // Shift the raw code through the synchronizer; it runs regardless of en
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        syncChain_q[i] <= 4'd0;
      end
    end else begin
      syncChain_q[0] <= {bus.A3, bus.A2, bus.A1, bus.A0};
      for (int i = 1; i < SYNC_STAGES; i++) begin
        syncChain_q[i] <= syncChain_q[i-1];
      end
    end
  end

  // Decode the synchronized code; hold the current outputs while en is low
  always_comb begin
    oneHot_d = oneHot_q;
    err_d    = err_q;
    if (bus.en) begin
      oneHot_d = 10'd0;
      err_d    = 1'b0;
      if (syncCode <= 4'd9) begin
        oneHot_d[syncCode] = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // A rising error flag marks entry into the invalid range; staying invalid,
  // or hopping between invalid codes, does not retrigger the count
  assign errRise = bus.en && err_d && !err_q;

  // Next counter value: clear wins over an increment and works even with en low
  always_comb begin
    errCnt_d = errCnt_q;
    if (bus.clr_cnt) begin
      errCnt_d = '0;
    end else if (errRise && (errCnt_q != CntMax)) begin
      errCnt_d = errCnt_q + 1'b1;
    end
  end

  // Output registers; reset presents decoded code 0 with a clean error state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oneHot_q <= 10'b00_0000_0001;
      err_q    <= 1'b0;
      errCnt_q <= '0;
    end else begin
      oneHot_q <= oneHot_d;
      err_q    <= err_d;
      errCnt_q <= errCnt_d;
    end
  end

  assign bus.O0      = oneHot_q[0];
  assign bus.O1      = oneHot_q[1];
  assign bus.O2      = oneHot_q[2];
  assign bus.O3      = oneHot_q[3];
  assign bus.O4      = oneHot_q[4];
  assign bus.O5      = oneHot_q[5];
  assign bus.O6      = oneHot_q[6];
  assign bus.O7      = oneHot_q[7];
  assign bus.O8      = oneHot_q[8];
  assign bus.O9      = oneHot_q[9];
  assign bus.ERR     = err_q;
  assign bus.ERR_CNT = errCnt_q;

endmodule

// File: tb/tb_bcd.sv
// Testbench for the BCD decoder. Two instances share one stimulus stream:
// dut0 uses the default configuration, dut1 a deeper synchronizer and a
// 2-bit error counter so saturation is reachable quickly.
module tb_bcd;

  localparam int S0 = 2;
  localparam int S1 = 3;
  localparam int W0 = 8;
  localparam int W1 = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] a = 4'd0;
  logic       en = 1'b0;
  logic       clrCnt = 1'b0;

  int nCompared = 0;
  int nMismatched = 0;

  // 10 ns clock, rising edges at 5, 15, 25 ...; stimulus changes 2 ns after a rising edge
  always #5 clk = ~clk;

  bcd_if #(.CNT_W(W0)) bus0 ();
  bcd_if #(.CNT_W(W1)) bus1 ();

  assign bus0.A0 = a[0];
  assign bus0.A1 = a[1];
  assign bus0.A2 = a[2];
  assign bus0.A3 = a[3];
  assign bus0.en = en;
  assign bus0.clr_cnt = clrCnt;
  assign bus1.A0 = a[0];
  assign bus1.A1 = a[1];
  assign bus1.A2 = a[2];
  assign bus1.A3 = a[3];
  assign bus1.en = en;
  assign bus1.clr_cnt = clrCnt;

  bcd #(.SYNC_STAGES(S0), .CNT_W(W0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  bcd #(.SYNC_STAGES(S1), .CNT_W(W1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  // Observed state packed as {ERR, O9..O0} and the counter zero-extended to 8 bits
  logic [10:0] obs [2];
  logic [7:0]  obsCnt [2];
  assign obs[0] = {bus0.ERR, bus0.O9, bus0.O8, bus0.O7, bus0.O6, bus0.O5,
                   bus0.O4, bus0.O3, bus0.O2, bus0.O1, bus0.O0};
  assign obs[1] = {bus1.ERR, bus1.O9, bus1.O8, bus1.O7, bus1.O6, bus1.O5,
                   bus1.O4, bus1.O3, bus1.O2, bus1.O1, bus1.O0};
  assign obsCnt[0] = bus0.ERR_CNT;
  assign obsCnt[1] = {6'd0, bus1.ERR_CNT};

  // Reference model: each input sample reaches the decoder a fixed number of
  // edges later (a plain delay line of codes); the decoder maps code v to bit v
  // or to the error bit, and the counter counts entries into the error state.
  int          stages [2] = '{S0, S1};
  int          cntMax [2] = '{255, 3};
  int          pipe [2][4];
  logic [10:0] expObs [2];
  int          expCnt [2];
  int          mv;
  logic        mRise;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < 4; i++) pipe[k][i] = 0;
        expObs[k] = 11'h001;
        expCnt[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        mv = pipe[k][stages[k]-1];
        for (int i = 3; i > 0; i--) pipe[k][i] = pipe[k][i-1];
        pipe[k][0] = int'(a);
        mRise = 1'b0;
        if (en) begin
          mRise = (mv >= 10) && !expObs[k][10];
          expObs[k] = (mv >= 10) ? 11'h400 : 11'(1 << mv);
        end
        if (clrCnt) expCnt[k] = 0;
        else if (mRise && expCnt[k] < cntMax[k]) expCnt[k] = expCnt[k] + 1;
      end
    end
  end

  // Drive one cycle of stimulus shortly after a rising edge, return at the next falling edge
  task automatic cycle(input logic [3:0] code, input logic e, input logic c);
    @(posedge clk);
    #2;
    a = code;
    en = e;
    clrCnt = c;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #2;
    a = 4'b0111;
    en = 1'b1;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      nCompared++;
      if (obs[k] !== 11'h001) begin
        nMismatched++;
        $display("[TB] FAIL reset dut%0d outputs: got %b want %b", k, obs[k], 11'h001);
      end
      nCompared++;
      if (obsCnt[k] !== 8'd0) begin
        nMismatched++;
        $display("[TB] FAIL reset dut%0d count: got %0d want 0", k, obsCnt[k]);
      end
    end
    repeat (3) @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      nCompared++;
      if (obs[k] !== 11'h001) begin
        nMismatched++;
        $display("[TB] FAIL reset_held dut%0d outputs: got %b want %b", k, obs[k], 11'h001);
      end
    end
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_sweep();
    for (int code = 0; code < 10; code++) begin
      for (int r = 0; r < 4; r++) begin
        cycle(4'(code), 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) begin
          nCompared++;
          if (obs[k] !== expObs[k]) begin
            nMismatched++;
            $display("[TB] FAIL sweep dut%0d code %0d outputs: got %b want %b", k, code, obs[k], expObs[k]);
          end
        end
        if (r == 3) begin
          nCompared++;
          if (obs[0] !== 11'(1 << code)) begin
            nMismatched++;
            $display("[TB] FAIL sweep_latency code %0d: got %b want %b", code, obs[0], 11'(1 << code));
          end
        end
      end
    end
  endtask

  task automatic test_invalid();
    int cntStart;
    cntStart = expCnt[0];
    for (int r = 0; r < 10; r++) begin
      cycle(4'd12, 1'b1, 1'b0);
      for (int k = 0; k < 2; k++) begin
        nCompared++;
        if (obs[k] !== expObs[k] || obsCnt[k] !== 8'(expCnt[k])) begin
          nMismatched++;
          $display("[TB] FAIL invalid dut%0d: got %b/%0d want %b/%0d", k, obs[k], obsCnt[k], expObs[k], expCnt[k]);
        end
      end
    end
    nCompared++;
    if (obs[0] !== 11'h400 || obsCnt[0] !== 8'(cntStart + 1)) begin
      nMismatched++;
      $display("[TB] FAIL invalid_hold: got %b/%0d want %b/%0d", obs[0], obsCnt[0], 11'h400, cntStart + 1);
    end
    for (int r = 0; r < 6; r++) begin
      cycle(4'd3, 1'b1, 1'b0);
      for (int k = 0; k < 2; k++) begin
        nCompared++;
        if (obs[k] !== expObs[k] || obsCnt[k] !== 8'(expCnt[k])) begin
          nMismatched++;
          $display("[TB] FAIL invalid_exit dut%0d: got %b/%0d want %b/%0d", k, obs[k], obsCnt[k], expObs[k], expCnt[k]);
        end
      end
    end
    nCompared++;
    if (obs[0] !== 11'h008 || obsCnt[0] !== 8'(cntStart + 1)) begin
      nMismatched++;
      $display("[TB] FAIL invalid_recover: got %b/%0d want %b/%0d", obs[0], obsCnt[0], 11'h008, cntStart + 1);
    end
  endtask

  task automatic test_hold();
    repeat (5) cycle(4'd5, 1'b1, 1'b0);
    for (int r = 0; r < 6; r++) begin
      cycle(4'd8, 1'b0, 1'b0);
      for (int k = 0; k < 2; k++) begin
        nCompared++;
        if (obs[k] !== 11'h020 || obs[k] !== expObs[k]) begin
          nMismatched++;
          $display("[TB] FAIL hold dut%0d: got %b want %b", k, obs[k], 11'h020);
        end
      end
    end
    cycle(4'd8, 1'b1, 1'b0);
    cycle(4'd8, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      nCompared++;
      if (obs[k] !== 11'h100 || obs[k] !== expObs[k]) begin
        nMismatched++;
        $display("[TB] FAIL hold_release dut%0d: got %b want %b", k, obs[k], 11'h100);
      end
    end
  endtask

  task automatic test_counter();
    for (int i = 0; i < 6; i++) begin
      for (int r = 0; r < 8; r++) begin
        cycle((r < 4) ? 4'd15 : 4'd0, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) begin
          nCompared++;
          if (obs[k] !== expObs[k] || obsCnt[k] !== 8'(expCnt[k])) begin
            nMismatched++;
            $display("[TB] FAIL counter dut%0d: got %b/%0d want %b/%0d", k, obs[k], obsCnt[k], expObs[k], expCnt[k]);
          end
        end
      end
    end
    nCompared++;
    if (obsCnt[1] !== 8'd3) begin
      nMismatched++;
      $display("[TB] FAIL counter_saturate: got %0d want 3", obsCnt[1]);
    end
    cycle(4'd0, 1'b0, 1'b1);
    cycle(4'd0, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      nCompared++;
      if (obsCnt[k] !== 8'd0) begin
        nMismatched++;
        $display("[TB] FAIL counter_clear dut%0d: got %0d want 0", k, obsCnt[k]);
      end
    end
    repeat (6) cycle(4'd15, 1'b1, 1'b1);
    repeat (3) cycle(4'd15, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      nCompared++;
      if (obsCnt[k] !== 8'd0 || obs[k] !== 11'h400) begin
        nMismatched++;
        $display("[TB] FAIL counter_clear_on_rise dut%0d: got %b/%0d want %b/0", k, obs[k], obsCnt[k], 11'h400);
      end
    end
    repeat (5) cycle(4'd0, 1'b1, 1'b0);
    repeat (5) cycle(4'd15, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      nCompared++;
      if (obsCnt[k] !== 8'd1) begin
        nMismatched++;
        $display("[TB] FAIL counter_recount dut%0d: got %0d want 1", k, obsCnt[k]);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] code;
    logic       e;
    int         hold;
    for (int n = 0; n < 80; n++) begin
      code = 4'($urandom_range(0, 15));
      e = ($urandom_range(0, 3) != 0);
      hold = $urandom_range(1, 5);
      for (int r = 0; r < hold; r++) begin
        cycle(code, e, ($urandom_range(0, 15) == 0));
        for (int k = 0; k < 2; k++) begin
          nCompared++;
          if (obs[k] !== expObs[k] || obsCnt[k] !== 8'(expCnt[k])) begin
            nMismatched++;
            $display("[TB] FAIL random dut%0d: got %b/%0d want %b/%0d", k, obs[k], obsCnt[k], expObs[k], expCnt[k]);
          end
        end
      end
    end
  endtask

  task automatic test_midreset();
    repeat (6) cycle(4'd13, 1'b1, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      nCompared++;
      if (obs[k] !== 11'h001 || obsCnt[k] !== 8'd0) begin
        nMismatched++;
        $display("[TB] FAIL midreset dut%0d: got %b/%0d want %b/0", k, obs[k], obsCnt[k], 11'h001);
      end
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int r = 0; r < 6; r++) begin
      cycle(4'd13, 1'b1, 1'b0);
      for (int k = 0; k < 2; k++) begin
        nCompared++;
        if (obs[k] !== expObs[k] || obsCnt[k] !== 8'(expCnt[k])) begin
          nMismatched++;
          $display("[TB] FAIL midreset_resume dut%0d: got %b/%0d want %b/%0d", k, obs[k], obsCnt[k], expObs[k], expCnt[k]);
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      nCompared++;
      if (obsCnt[k] !== 8'd1) begin
        nMismatched++;
        $display("[TB] FAIL midreset_recount dut%0d: got %0d want 1", k, obsCnt[k]);
      end
    end
  endtask

  task automatic test_async();
    @(posedge clk);
    #2;
    en = 1'b1;
    clrCnt = 1'b0;
    a = 4'b0010;
    fork
      begin
        repeat (50) begin
          #20;
          a[0] = ~a[0];
        end
      end
      begin
        repeat (33) begin
          #30;
          a[1] = ~a[1];
        end
      end
      begin
        #10;
        repeat (33) begin
          #30;
          a[2] = ~a[2];
        end
      end
      begin
        #20;
        repeat (32) begin
          #30;
          a[3] = ~a[3];
        end
      end
      begin
        repeat (100) begin
          @(negedge clk);
          for (int k = 0; k < 2; k++) begin
            nCompared++;
            if ($countones(obs[k]) > 1) begin
              nMismatched++;
              $display("[TB] FAIL async_exclusive dut%0d: got %b", k, obs[k]);
            end
            nCompared++;
            if (obs[k] !== expObs[k] || obsCnt[k] !== 8'(expCnt[k])) begin
              nMismatched++;
              $display("[TB] FAIL async dut%0d: got %b/%0d want %b/%0d", k, obs[k], obsCnt[k], expObs[k], expCnt[k]);
            end
          end
        end
      end
    join
  endtask

  // Run every scenario in order, then report
  initial begin
    test_reset();
    test_sweep();
    test_invalid();
    test_hold();
    test_counter();
    test_random();
    test_midreset();
    test_async();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
